ddr_traffic_gen_chk: RTL and testbench

Synthesizable, parametrised traffic generator and checker for the DRAM controller command port. It issues 34-bit write/read commands over a configurable rank/bank/row/column window and generates write data as a deterministic function of address and seed, so no data table is needed. It checks in-order read return against an internal expected-address FIFO and reports error, count and timeout status. It replaces table-driven bench stimulus and sits directly on the controller's command, write_data, read_data and ba_cmd_pm ports.

---
 rtl/ddr_tg_pkg.sv | 21 ++
 rtl/ddr_tg_fifo.sv | 34 +++
 rtl/ddr_traffic_gen_chk.sv | 196 +++++++++++++++++++
 tb/tb_ddr_traffic_gen_chk.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_tg_pkg.sv
// ddr_tg_pkg: shared types, command layout and data/address helpers for the traffic generator
package ddr_tg_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE_W, ISSUE_R, ISSUE_WR, DRAIN, DONE} state_e;
   localparam int MODE_PAIR = 0;
   localparam int MODE_BANK_FAST = 1;
   localparam int CMD_BANK = 0;
   localparam int CMD_COL = 3;
   localparam int CMD_BL = 15;
   localparam int CMD_ROW = 17;
   localparam int CMD_RW = 31;
   localparam int CMD_RANK = 32;
   // rank occupies the lowest bits, then bank, row and column
   function automatic logic [31:0] pack_addr(logic [1:0] rank, logic [2:0] bank, logic [12:0] row, logic [9:0] col);
      return {4'b0, col, row, bank, rank};
   endfunction
   function automatic logic [127:0] pattern(logic [31:0] a, logic [31:0] seed);
      logic [31:0] w;
      w = seed ^ a;
      return {w ^ 32'hA5A5A5A5, w[15:0], w[31:16], ~w, w};
   endfunction
endpackage

// File: rtl/ddr_tg_fifo.sv
// ddr_tg_fifo: synchronous FIFO of outstanding read addresses
module ddr_tg_fifo #(
   parameter int W = 32,
   parameter int D = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(D);
   logic [W-1:0] mem_q [D];
   logic [AW:0] wp_q, rp_q;
   assign empty_o = wp_q == rp_q;
   assign full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign dout_o = mem_q[rp_q[AW-1:0]];
   // pointer update; push and pop may happen in the same cycle
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (push_i && !full_o) wp_q <= wp_q + 1'b1;
         if (pop_i && !empty_o) rp_q <= rp_q + 1'b1;
      end
   end
   // storage write
   always_ff @(posedge clk) if (push_i && !full_o) mem_q[wp_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/ddr_traffic_gen_chk.sv
// ddr_traffic_gen_chk: address-driven DRAM command generator with in-order read checker
module ddr_traffic_gen_chk
   import ddr_tg_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int ROW_W = 13,
   parameter int COL_W = 10,
   parameter int RD_FIFO_DEPTH = 16,
   parameter int CNT_W = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              power_on_rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [1:0]        num_rank,
   input  logic [2:0]        num_bank,
   input  logic [CNT_W-1:0]  num_row,
   input  logic [CNT_W-1:0]  num_col,
   input  logic [31:0]       seed,
   input  logic [7:0]        ba_cmd_pm,
   output logic [33:0]       command,
   output logic              valid,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data,
   input  logic              read_data_valid,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  spurious_cnt,
   output logic [31:0]       first_err_addr,
   output logic              timeout
);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_e st_q;
   logic bf_q, ph_q, valid_q, to_q;
   logic [33:0] cmd_q, cmd_w;
   logic [DATA_W-1:0] wd_q;
   logic [1:0] rank_q, rank_d;
   logic [2:0] bank_q, bank_d;
   logic [CNT_W-1:0] row_q, row_d, col_q, col_d, err_q, rd_q, sp_q;
   logic [31:0] fea_q, a_w, fifo_dout;
   logic [TW-1:0] tmo_q;
   logic go, issuing, rw, fire, adv, last, full, empty, pop, col_end, row_end, bank_end, rank_end;

   function automatic logic [DATA_W-1:0] expand(logic [127:0] p);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W / 32; i++) r[32*i+:32] = p[32*(i%4)+:32];
      return r;
   endfunction

   assign go = start && (st_q == IDLE || st_q == DONE);
   assign issuing = st_q == ISSUE_W || st_q == ISSUE_R || st_q == ISSUE_WR;
   assign rw = st_q == ISSUE_R || (st_q == ISSUE_WR && ph_q);
   assign fire = issuing && ba_cmd_pm[bank_q] && !(rw && full);
   assign adv = fire && (st_q != ISSUE_WR || ph_q);
   assign col_end = col_q == num_col;
   assign row_end = row_q == num_row;
   assign bank_end = bank_q == num_bank;
   assign rank_end = rank_q == num_rank;
   assign last = col_end && row_end && bank_end && rank_end;
   assign a_w = pack_addr(rank_q, bank_q, row_q[ROW_W-1:0], col_q[COL_W-1:0]);
   assign pop = read_data_valid && st_q != IDLE;

   // next address: innermost field per order, carries ripple outward; rank is always outermost
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      bank_d = bank_q;
      rank_d = rank_q;
      if (adv) begin
         if (!bf_q) begin
            col_d = col_end ? '0 : col_q + 1'b1;
            row_d = col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
            bank_d = col_end && row_end ? (bank_end ? '0 : bank_q + 1'b1) : bank_q;
         end else begin
            bank_d = bank_end ? '0 : bank_q + 1'b1;
            col_d = bank_end ? (col_end ? '0 : col_q + 1'b1) : col_q;
            row_d = bank_end && col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
         end
         rank_d = col_end && row_end && bank_end ? (rank_end ? '0 : rank_q + 1'b1) : rank_q;
      end
   end

   // command word assembly for the current address
   always_comb begin
      cmd_w = '0;
      cmd_w[CMD_RANK+:2] = rank_q;
      cmd_w[CMD_RW] = rw;
      cmd_w[CMD_ROW+:ROW_W] = row_q[ROW_W-1:0];
      cmd_w[CMD_BL] = 1'b1;
      cmd_w[CMD_COL+:COL_W] = col_q[COL_W-1:0];
      cmd_w[CMD_BANK+:3] = bank_q;
   end

   // address counters, cleared on every accepted start
   always_ff @(posedge clk) begin
      if (power_on_rst || go) begin
         rank_q <= '0;
         bank_q <= '0;
         row_q <= '0;
         col_q <= '0;
      end else begin
         rank_q <= rank_d;
         bank_q <= bank_d;
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   // control FSM with registered command outputs and drain timeout
   always_ff @(posedge clk) begin
      if (power_on_rst) begin
         st_q <= IDLE;
         bf_q <= 1'b0;
         ph_q <= 1'b0;
         valid_q <= 1'b0;
         cmd_q <= '0;
         wd_q <= '0;
         tmo_q <= '0;
         to_q <= 1'b0;
      end else begin
         valid_q <= fire;
         cmd_q <= fire ? cmd_w : '0;
         wd_q <= fire && !rw ? expand(pattern(a_w, seed)) : '0;
         if (fire && st_q == ISSUE_WR) ph_q <= !ph_q;
         case (st_q)
            IDLE, DONE: if (start) begin
               st_q <= mode[MODE_PAIR] ? ISSUE_WR : ISSUE_W;
               bf_q <= mode[MODE_BANK_FAST];
               ph_q <= 1'b0;
               to_q <= 1'b0;
            end
            ISSUE_W: if (fire && last) st_q <= ISSUE_R;
            ISSUE_R, ISSUE_WR: if (fire && rw && last) begin
               st_q <= DRAIN;
               tmo_q <= TW'(TIMEOUT);
            end
            DRAIN: begin
               if (empty) st_q <= DONE;
               else if (pop) tmo_q <= TW'(TIMEOUT);
               else if (tmo_q == '0) begin
                  st_q <= DONE;
                  to_q <= 1'b1;
               end else tmo_q <= tmo_q - 1'b1;
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   // read-return checker with saturating counters
   always_ff @(posedge clk) begin
      if (power_on_rst || go) begin
         err_q <= '0;
         rd_q <= '0;
         sp_q <= '0;
         fea_q <= '0;
      end else if (pop) begin
         if (empty) sp_q <= sp_q + CNT_W'(~&sp_q);
         else begin
            rd_q <= rd_q + CNT_W'(~&rd_q);
            if (read_data != expand(pattern(fifo_dout, seed))) begin
               err_q <= err_q + CNT_W'(~&err_q);
               if (err_q == '0) fea_q <= fifo_dout;
            end
         end
      end
   end

   ddr_tg_fifo #(.W(32), .D(RD_FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(power_on_rst),
      .clr_i(go),
      .push_i(fire && rw),
      .din_i(a_w),
      .pop_i(pop),
      .dout_o(fifo_dout),
      .full_o(full),
      .empty_o(empty)
   );

   assign command = cmd_q;
   assign valid = valid_q;
   assign write_data = wd_q;
   assign busy = issuing || st_q == DRAIN;
   assign done = st_q == DONE;
   assign pass = done && err_q == '0 && !to_q && sp_q == '0;
   assign err_cnt = err_q;
   assign rd_cnt = rd_q;
   assign spurious_cnt = sp_q;
   assign first_err_addr = fea_q;
   assign timeout = to_q;
endmodule

// File: tb/tb_ddr_traffic_gen_chk.sv
// tb_ddr_traffic_gen_chk: directed bench with an ideal controller model
module tb_ddr_traffic_gen_chk;
   logic clk = 0, power_on_rst = 1, start = 0, read_data_valid = 0;
   logic [1:0] mode = 0, num_rank = 0;
   logic [2:0] num_bank = 0;
   logic [15:0] num_row = 0, num_col = 0, err_cnt, rd_cnt, spurious_cnt;
   logic [31:0] seed = 0, first_err_addr;
   logic [7:0] ba_cmd_pm = 8'hFF, pm_prev = 8'hFF;
   logic [33:0] command, first_w, first_r, last_w;
   logic [127:0] write_data, read_data = 0, first_wd;
   logic valid, busy, done, pass, timeout;
   logic [127:0] mem [logic [31:0]];
   logic [127:0] rq [$];
   logic [31:0] last_wa;
   logic prev_rw = 1, hold = 0, stray = 0, tog = 0, chk_ord = 0;
   int total = 0, bad = 0, nw = 0, nr = 0, cyc = 0, last_ret = 0;
   int alt_bad = 0, order_bad = 0, perm_bad = 0, data_bad = 0, flip_idx = -1, drop_from = 1 << 30;

   ddr_traffic_gen_chk dut (
      .clk(clk), .power_on_rst(power_on_rst), .start(start), .mode(mode),
      .num_rank(num_rank), .num_bank(num_bank), .num_row(num_row), .num_col(num_col),
      .seed(seed), .ba_cmd_pm(ba_cmd_pm), .command(command), .valid(valid),
      .write_data(write_data), .read_data(read_data), .read_data_valid(read_data_valid),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .rd_cnt(rd_cnt),
      .spurious_cnt(spurious_cnt), .first_err_addr(first_err_addr), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pk(logic [33:0] c);
      return {4'b0, c[12:3], c[29:17], c[2:0], c[33:32]};
   endfunction

   function automatic logic [127:0] pat(logic [31:0] a, logic [31:0] s);
      logic [31:0] w;
      w = s ^ a;
      return {w ^ 32'hA5A5A5A5, w[15:0], w[31:16], ~w, w};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // controller model: observes commands, stores writes, returns reads in order
   always @(negedge clk) begin
      logic [31:0] a;
      int idx;
      cyc++;
      read_data_valid = 0;
      read_data = '0;
      if (valid) begin
         a = pk(command);
         idx = command[31] ? nr : nw;
         if (chk_ord && (int'(command[2:0]) != idx % 4 || int'(command[12:3]) != idx / 4)) order_bad++;
         if (!pm_prev[command[2:0]]) perm_bad++;
         if (mode[0] && command[31] == prev_rw) alt_bad++;
         prev_rw = command[31];
         if (!command[31]) begin
            if (nw == 0) begin
               first_w = command;
               first_wd = write_data;
            end
            last_w = command;
            last_wa = a;
            if (write_data !== pat(a, seed)) data_bad++;
            mem[a] = write_data;
            nw++;
         end else begin
            if (nr == 0) first_r = command;
            if (mode[0] && a != last_wa) alt_bad++;
            if (nr < drop_from) rq.push_back((mem.exists(a) ? mem[a] : '0) ^ {127'b0, nr == flip_idx});
            nr++;
         end
      end
      if (stray) begin
         read_data_valid = 1;
         stray = 0;
      end else if (!hold && rq.size() > 0) begin
         read_data = rq.pop_front();
         read_data_valid = 1;
         last_ret = cyc;
      end
      if (tog) ba_cmd_pm = ba_cmd_pm == 8'h05 ? 8'h0A : 8'h05;
      pm_prev = ba_cmd_pm;
   end

   task automatic start_run(input logic [1:0] m, input logic [1:0] rk, input logic [2:0] bk,
                            input int rows, input int cols, input logic [31:0] sd);
      mode = m; num_rank = rk; num_bank = bk; num_row = 16'(rows); num_col = 16'(cols); seed = sd;
      nw = 0; nr = 0; prev_rw = 1; alt_bad = 0; order_bad = 0; perm_bad = 0; data_bad = 0;
      rq.delete();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, done, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      power_on_rst = 0;
      chk("rst_valid", valid, 0);
      chk("rst_cmd", command, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      // 1: all writes then all reads over 32x16
      start_run(2'd0, 2'd0, 3'd0, 31, 15, 32'h0);
      wait_done("t1_done", 3000);
      chk("t1_nw", nw, 512);
      chk("t1_nr", nr, 512);
      chk("t1_rd", rd_cnt, 512);
      chk("t1_err", err_cnt, 0);
      chk("t1_pass", pass, 1);
      chk("t1_data", data_bad, 0);
      chk("t1_first_w", first_w, 34'h0_0000_8000);
      chk("t1_first_wd", first_wd, {32'hA5A5A5A5, 32'h0, 32'hFFFFFFFF, 32'h0});
      chk("t1_first_r", first_r, 34'h0_8000_8000);
      chk("t1_last_w", last_w, 34'h0_003E_8078);
      // 2: write/read pairs over 2x2x2x2
      start_run(2'd1, 2'd1, 3'd1, 1, 1, 32'h1234_5678);
      wait_done("t2_done", 500);
      chk("t2_nw", nw, 16);
      chk("t2_nr", nr, 16);
      chk("t2_alt", alt_bad, 0);
      chk("t2_data", data_bad, 0);
      chk("t2_pass", pass, 1);
      // 3: bank-fastest with alternating bank permissions
      ba_cmd_pm = 8'h05;
      tog = 1;
      chk_ord = 1;
      start_run(2'd2, 2'd0, 3'd3, 0, 1, 32'hDEAD_BEEF);
      wait_done("t3_done", 500);
      tog = 0;
      chk_ord = 0;
      ba_cmd_pm = 8'hFF;
      chk("t3_nw", nw, 8);
      chk("t3_order", order_bad, 0);
      chk("t3_perm", perm_bad, 0);
      chk("t3_pass", pass, 1);
      // 4: corrupt read index 5 (row 1, col 1)
      flip_idx = 5;
      start_run(2'd0, 2'd0, 3'd0, 1, 3, 32'hCAFE_F00D);
      wait_done("t4_done", 500);
      flip_idx = -1;
      chk("t4_err", err_cnt, 1);
      chk("t4_rd", rd_cnt, 8);
      chk("t4_fea", first_err_addr, 32'h0004_0020);
      chk("t4_pass", pass, 0);
      // 5: hold returns to fill the FIFO, then drop the final read
      hold = 1;
      drop_from = 16;
      start_run(2'd0, 2'd0, 3'd0, 0, 16, 32'h0BAD_CAFE);
      repeat (80) @(negedge clk);
      chk("t5_stall_nr", nr, 16);
      chk("t5_stall_valid", valid, 0);
      chk("t5_busy", busy, 1);
      hold = 0;
      wait_done("t5_done", 6000);
      drop_from = 1 << 30;
      chk("t5_timeout", timeout, 1);
      chk("t5_nr", nr, 17);
      chk("t5_rd", rd_cnt, 16);
      chk("t5_pass", pass, 0);
      chk("t5_window", (cyc - last_ret >= 4090) && (cyc - last_ret <= 4110), 1);
      // 6: reset during reads, then one stray response after a fresh start
      start_run(2'd0, 2'd0, 3'd0, 0, 7, 32'h5555_AAAA);
      begin
         int n = 0;
         while (nr < 2 && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      chk("t6_reach", nr >= 2, 1);
      power_on_rst = 1;
      @(negedge clk);
      power_on_rst = 0;
      chk("t6_valid", valid, 0);
      chk("t6_cmd", command, 0);
      chk("t6_wd", write_data, 0);
      chk("t6_busy", busy, 0);
      chk("t6_rd", rd_cnt, 0);
      chk("t6_timeout", timeout, 0);
      repeat (20) @(negedge clk);
      chk("t6_idle_sp", spurious_cnt, 0);
      start_run(2'd0, 2'd0, 3'd0, 0, 7, 32'h5555_AAAA);
      stray = 1;
      wait_done("t6_done", 500);
      chk("t6_sp", spurious_cnt, 1);
      chk("t6_err", err_cnt, 0);
      chk("t6_rd2", rd_cnt, 8);
      chk("t6_pass", pass, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
